rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that produces the registered 2-bit grant index consumed by the team's 2-to-4 decoder, with grant_idx[1] on decoder input A and grant_idx[0] on decoder input B. The decoder turns the index into a one-hot enable. This block owns fairness, grant holding, forced rotation after a bounded hold time, and the idle bubble between grants.

## Interface
- MAX_HOLD, default 8: maximum cycles one grant may stay active before forced release; legal range 2..256.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous reset, active low.
- req  input  4  request vector; bit i set means requester i wants the resource.
- release  input  1  current grantee done; sampled only while grant_valid=1.
- grant_valid  output  1  a grant is active this cycle; registered.
- grant_idx  output  2  index of current grantee; registered; held stable while grant_valid=1.
- hold_cnt  output  W  cycles elapsed in the current grant, W = max(1, clog2(MAX_HOLD)); 0 on the first grant cycle; debug/visibility.

## Operation
- State: fsm in {IDLE, BUSY}; ptr[1:0] is the highest-priority requester for the next arbitration; hold_cnt.
- Reset (rst_n=0 at a clk edge):
  - fsm=IDLE, ptr=0, grant_valid=0, grant_idx=2'b00, hold_cnt=0.
  - Reset applies at any point, including mid-grant; the next cycle is IDLE with no grant.
- IDLE, req==0: stay IDLE; outputs unchanged apart from grant_valid=0.
- IDLE, req!=0:
  - Winner w is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: fsm=BUSY, grant_valid=1, grant_idx=w, hold_cnt=0, ptr=w+1 (mod 4, wraps 3→0).
- BUSY, release condition: any of the following in the current cycle:
  - release=1;
  - req[grant_idx]=0;
  - hold_cnt==MAX_HOLD-1.
- BUSY, release condition true: next cycle fsm=IDLE, grant_valid=0, hold_cnt=0. grant_idx keeps its last value.
- BUSY, release condition false: hold_cnt increments; grant_idx unchanged.
- Multiple release causes in the same cycle count as a single release. Nothing double-counts and ptr does not move again.
- Requests from non-granted requesters during BUSY are ignored until the next arbitration. No preemption.
- A forced-released requester that still requests competes normally. It wins again only if no other requester is set, because ptr has already advanced past it.

## Timing
- Request to grant latency: req sampled in IDLE at edge t gives grant_valid=1 from edge t+1.
- Release to idle: release condition at edge t gives grant_valid=0 for exactly one cycle from t+1. The earliest next grant is at t+2.
  - One mandatory bubble between consecutive grants.
- Maximum grant length: MAX_HOLD cycles with grant_valid=1.
- Worst-case wait for a continuously requesting requester: 3×(MAX_HOLD+1)+1 cycles from its request to its grant.
- All outputs change only on clk rising edges. No combinational path from inputs to outputs.

## Test plan
- Reset and single request:
  - Stimulus: hold rst_n=0 for 2 cycles, release reset, then req=4'b0100 held.
  - Required: grant_valid=0 and grant_idx=00 during reset; grant_valid=1, grant_idx=10 one cycle after req is sampled.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held, release pulsed on every grant's first cycle.
  - Required: grant_idx sequence 00, 01, 10, 11, 00, with grant_valid low for one cycle between each grant.
- Wrap-around priority:
  - Stimulus: after a grant to 11, req=4'b0011.
  - Required: the next grant goes to 00, not 01.
- Forced release:
  - Stimulus: MAX_HOLD=4, req=4'b0011 held, release=0.
  - Required: grant 00 for exactly 4 cycles with hold_cnt 0,1,2,3; one idle cycle; then grant 01.
- Request drop and simultaneous causes:
  - Stimulus (a): granted requester drops its req on cycle 2.
  - Required (a): grant_valid=0 on the next cycle.
  - Stimulus (b): release=1, req drop and hold_cnt==MAX_HOLD-1 all in one cycle.
  - Required (b): a single idle cycle and ptr advanced exactly once.
- Reset mid-grant:
  - Stimulus: rst_n=0 for one cycle while BUSY with grant_idx=10.
  - Required: grant_valid=0, grant_idx=00 and ptr=0 next cycle; with req=4'b1111 afterwards, the first grant is 00.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded grant length.
//
// A registered 2-bit grant index is sent to a 2-to-4 decoder:
// grant_idx[1] drives decoder input A and grant_idx[0] drives input B.
//
// Each grant stays active until one of these happens:
//   - the grantee signals it is done,
//   - the grantee drops its request,
//   - the grant reaches MAX_HOLD cycles.
// After every grant there is exactly one idle cycle.
//
// The "done" input is named release_now because `release` is a reserved
// word in SystemVerilog.
module rr_arbiter_4 #(
  parameter  int MAX_HOLD = 8,
  localparam int W        = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic         release_now,
  output logic         grant_valid,
  output logic [1:0]   grant_idx,
  output logic [W-1:0] hold_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [W-1:0] HOLD_LAST = W'(MAX_HOLD - 1);

  state_t       state_reg;
  logic [1:0]   ptr_reg;
  logic         grant_valid_reg;
  logic [1:0]   grant_idx_reg;
  logic [W-1:0] hold_cnt_reg;

  // Candidate gi is the requester gi places after the pointer, so the
  // scan order is ptr, ptr+1, ptr+2, ptr+3 with 2-bit wrap.
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = ptr_reg + 2'(gi);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  logic [1:0] winner;
  logic       any_req;
  logic       hold_last;
  logic       rel_cond;

  // Priority pick: the lowest candidate offset that is requesting wins.
  always_comb begin
    winner = cand_idx[0];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        winner = cand_idx[i];
      end
    end
  end

  assign any_req   = |req;
  assign hold_last = (hold_cnt_reg == HOLD_LAST);

  // All three release causes are merged into one event, so a cycle with
  // several causes still ends the grant only once.
  assign rel_cond  = release_now | ~req[grant_idx_reg] | hold_last;

  // Arbiter state machine; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= 2'd0;
      grant_valid_reg <= 1'b0;
      grant_idx_reg   <= 2'b00;
      hold_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg       <= BUSY;
            grant_valid_reg <= 1'b1;
            grant_idx_reg   <= winner;
            hold_cnt_reg    <= '0;
            // The pointer moves past the winner at grant time, so a
            // forced-off requester does not get the next grant first.
            ptr_reg         <= winner + 2'd1;
          end else begin
            grant_valid_reg <= 1'b0;
          end
        end
        BUSY: begin
          if (rel_cond) begin
            // grant_idx keeps its last value through the idle bubble.
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            hold_cnt_reg    <= '0;
          end else begin
            hold_cnt_reg    <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          grant_valid_reg <= 1'b0;
          hold_cnt_reg    <= '0;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_reg;
  assign grant_idx   = grant_idx_reg;
  assign hold_cnt    = hold_cnt_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed testbench for rr_arbiter_4, built with MAX_HOLD=4.
// The expected values in each step were worked out by hand.
module tb_rr_arbiter_4;

  localparam int MH = 4;
  localparam int W  = 2;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic         rel;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [W-1:0] hold_cnt;

  int total;
  int bad;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .release_now (rel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .hold_cnt    (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one clock edge, then let outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%b req=%b rel=%b -> gv=%b idx=%0d hc=%0d",
             $time, rst_n, req, rel, grant_valid, grant_idx, hold_cnt);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int idx, input int hc);
    chk({tag, "_gv"}, 32'(grant_valid), 32'd1);
    chk({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, "_hc"}, 32'(hold_cnt), 32'(hc));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gv"}, 32'(grant_valid), 32'd0);
    chk({tag, "_hc"}, 32'(hold_cnt), 32'd0);
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;

    // Reset for two cycles, then a single request from requester 2.
    tick();
    chk_idle("rst0");
    chk("rst0_idx", 32'(grant_idx), 32'd0);
    tick();
    chk_idle("rst1");
    chk("rst1_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    chk_grant("single", 2, 0);

    // The grantee drops its request, which ends the grant.
    req = 4'b0000;
    tick();
    chk_idle("single_drop");
    chk("single_drop_idx", 32'(grant_idx), 32'd2);

    // With no requests, the arbiter stays idle.
    tick();
    chk_idle("idle_noreq");

    // Reset to bring the pointer back to 0, then test round-robin with
    // release pulsed on the first cycle of each grant.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_grant($sformatf("rr%0d", k), exp_seq[k], 0);
      rel = 1'b1;
      tick();
      chk_idle($sformatf("rr%0d_bubble", k));
      rel = 1'b0;
    end

    // Wrap-around: a grant to 3 leaves the pointer at 0, so with req=0011
    // the next grant goes to 0.
    req = 4'b1000;
    tick();
    chk_grant("wrap_g3", 3, 0);
    rel = 1'b1;
    req = 4'b0011;
    tick();
    chk_idle("wrap_bubble");
    rel = 1'b0;
    tick();
    chk_grant("wrap_g0", 0, 0);

    // Forced release: requester 0 keeps requesting and is cut off after
    // 4 cycles; requester 1 gets the next grant.
    for (int k = 1; k < MH; k++) begin
      tick();
      chk_grant($sformatf("force_hc%0d", k), 0, k);
    end
    tick();
    chk_idle("force_bubble");
    tick();
    chk_grant("force_next", 1, 0);

    // Request drop on the second cycle of the grant.
    tick();
    chk_grant("drop_c1", 1, 1);
    req = 4'b0001;
    tick();
    chk_idle("drop_idle");
    tick();
    chk_grant("drop_next", 0, 0);

    // Release, request drop and hold limit all occur in the same cycle.
    // If the pointer moves only once, requester 1 wins; if it moved
    // twice, requester 2 would win.
    for (int k = 1; k < MH; k++) begin
      tick();
      chk_grant($sformatf("multi_hc%0d", k), 0, k);
    end
    rel = 1'b1;
    req = 4'b0110;
    tick();
    chk_idle("multi_idle");
    rel = 1'b0;
    tick();
    chk_grant("multi_next", 1, 0);

    // Reset while requester 2 holds the grant.
    rel = 1'b1;
    tick();
    chk_idle("pre_mid_idle");
    rel = 1'b0;
    tick();
    chk_grant("pre_mid_g2", 2, 0);
    rst_n = 1'b0;
    tick();
    chk_idle("mid_rst");
    chk("mid_rst_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    chk_grant("post_rst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
